// File: rtl/microcode_bootstrap.sv
// Microcode LUT bootstrap writer: takes a byte stream over valid/ready, programs the LUT
// one byte plane per word (MSB first), then verifies a trailing mod-256 checksum.
module microcode_bootstrap #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORDS      = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [ADDR_WIDTH-1:0] BOOTSTRAP_ADDR,
  output logic [7:0]            BOOTSTRAP_DATA,
  output logic [1:0]            BOOTSTRAP_PLANE,
  output logic                  BOOTSTRAP_N_WE,
  output logic                  N_BOOTED,
  output logic                  ERROR
);

  // S_RESET exists only so IN_READY stays low while RST is held; it always exits to S_LOAD.
  typedef enum logic [2:0] {
    S_RESET, S_LOAD, S_SETUP, S_STROBE, S_HOLD, S_CHECK, S_DONE, S_FAIL
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] checksum;
  logic [7:0] checksum_final;
  logic       last_byte;

  assign checksum_final = checksum + IN_DATA;
  assign last_byte      = (BOOTSTRAP_ADDR == LAST_ADDR) && (BOOTSTRAP_PLANE == 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_RESET;
    else     state <= state_next;
  end

  // NOTE: every output and state_next gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    IN_READY       = 1'b0;
    BOOTSTRAP_N_WE = 1'b1;
    N_BOOTED       = 1'b1;
    ERROR          = 1'b0;
    case (state)
      S_RESET:  state_next = S_LOAD;
      S_LOAD: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_next = S_SETUP;
      end
      S_SETUP:  state_next = S_STROBE;
      S_STROBE: begin
        BOOTSTRAP_N_WE = 1'b0;
        state_next     = S_HOLD;
      end
      S_HOLD:   state_next = last_byte ? S_CHECK : S_LOAD;
      S_CHECK: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_next = (checksum_final == 8'd0) ? S_DONE : S_FAIL;
      end
      S_DONE:   N_BOOTED = 1'b0;
      S_FAIL:   ERROR = 1'b1;
      default:  state_next = S_RESET;
    endcase
  end

  // NOTE: the datapath is a handful of flops (no memory array), so all of it is reset
  // to give the LUT a defined address/plane/data while held in reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BOOTSTRAP_ADDR  <= '0;
      BOOTSTRAP_DATA  <= 8'd0;
      BOOTSTRAP_PLANE <= 2'd3;
      checksum        <= 8'd0;
    end else begin
      case (state)
        S_LOAD: begin
          if (IN_VALID) begin
            BOOTSTRAP_DATA <= IN_DATA;
            checksum       <= checksum_final;
          end
        end
        S_HOLD: begin
          // The last word never increments the address; it hands over to the checksum phase.
          if (last_byte) begin
            BOOTSTRAP_ADDR  <= '0;
            BOOTSTRAP_PLANE <= 2'd3;
          end else if (BOOTSTRAP_PLANE == 2'd0) begin
            BOOTSTRAP_ADDR  <= BOOTSTRAP_ADDR + ADDR_WIDTH'(1);
            BOOTSTRAP_PLANE <= 2'd3;
          end else begin
            BOOTSTRAP_PLANE <= BOOTSTRAP_PLANE - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/microcode_bootstrap.md
Name: microcode_bootstrap

Overview:
- Writer side of the microcode LUT bootstrap port.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver or an SPI flash reader.
- Programs each microcode word one byte plane at a time, driving BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_PLANE and BOOTSTRAP_N_WE.
- After the whole image and a trailing checksum byte are verified, it releases N_BOOTED so the LUT drives control logic.

Parameters:
- ADDR_WIDTH, 12, microcode address width; must match the LUT DEPTH.
- WORDS, 4096, number of 32-bit words in the image; range 1..2^ADDR_WIDTH.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_DATA  input  8  image byte from the upstream source.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  block accepts IN_DATA this cycle.
- BOOTSTRAP_ADDR  output  ADDR_WIDTH  microcode word address being programmed.
- BOOTSTRAP_DATA  output  8  byte being programmed.
- BOOTSTRAP_PLANE  output  2  byte plane: 3 = OUT[31:24] … 0 = OUT[7:0].
- BOOTSTRAP_N_WE  output  1  active-low write strobe to the LUT.
- N_BOOTED  output  1  1 = still bootstrapping (LUT outputs disabled); 0 = image valid.
- ERROR  output  1  checksum mismatch; sticky until RST.

Behaviour:
- Clocking: one clock; RST is synchronous and active-high. All outputs are registered or decoded directly from the state register; no combinational path from IN_VALID to any output.
- Reset values: IN_READY=0, BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0, BOOTSTRAP_PLANE=3, BOOTSTRAP_N_WE=1, N_BOOTED=1, ERROR=0, checksum accumulator=0.
- Reset exit: the cycle after RST deasserts, the state is LOAD.
- States: LOAD, SETUP, STROBE, HOLD, CHECK, DONE, FAIL.
- LOAD: IN_READY=1.
  - On IN_VALID&IN_READY: BOOTSTRAP_DATA<=IN_DATA; checksum<=checksum+IN_DATA (mod 256); go to SETUP.
  - IN_VALID=0 stays in LOAD.
- SETUP: IN_READY=0, N_WE=1. Address, plane and data are stable. Go to STROBE.
- STROBE: N_WE=0 for exactly one cycle. Go to HOLD.
- HOLD: N_WE=1; address, plane and data unchanged. Then advance:
  - plane>0: plane-1.
  - plane==0: plane<=3, addr+1.
  - If the byte just written was addr==WORDS-1, plane==0: go to CHECK (addr<=0, plane<=3). Otherwise go to LOAD.
- Throughput: a byte accepted at cycle t gives SETUP at t+1, strobe at t+2, HOLD at t+3, and IN_READY=1 again at t+4. Maximum rate is one byte per 4 cycles.
- Byte order: word-major. Within each word the MSB plane (3) comes first.
- CHECK: IN_READY=1.
  - On accept: if (checksum+IN_DATA) mod 256 == 0, go to DONE; otherwise go to FAIL.
  - No LUT write occurs in CHECK.
- DONE: N_BOOTED=0, IN_READY=0, N_WE=1. Terminal until RST.
- FAIL: ERROR=1, N_BOOTED=1, IN_READY=0, N_WE=1. Terminal until RST.
- Handshake: IN_VALID while IN_READY=0 is ignored. Upstream holds IN_DATA until accepted. Bytes offered after DONE or FAIL are never accepted.
- Reset mid-operation (including during STROBE): N_WE=1 from the next cycle and all state returns to reset values. Partial LUT contents remain, but N_BOOTED stays 1 until a full, correctly checksummed image completes.
- Checksum: two's-complement mod-256 sum. The image bytes plus the checksum byte must total 0x00.
- WORDS=2^ADDR_WIDTH: the address counter does not wrap past the last word; the transition to CHECK is taken instead.

Test Plan:
1. Reset values. Hold RST 3 cycles, then release with IN_VALID=0 -> IN_READY=1 from the first post-reset cycle; N_WE=1, N_BOOTED=1, ERROR=0, ADDR=0, PLANE=3 held indefinitely.
2. Good image, back-to-back. WORDS=2; stream 0x01..0x08 with IN_VALID always high, then checksum 0xDC ->
   - exactly 8 single-cycle N_WE pulses, spaced 4 cycles apart;
   - (ADDR,PLANE,DATA) sequence (0,3,01),(0,2,02),(0,1,03),(0,0,04),(1,3,05)…(1,0,08);
   - N_BOOTED=0 the cycle after the checksum is accepted; ERROR=0.
3. Bad checksum. Same image with checksum 0x00 -> ERROR=1 and N_BOOTED=1 after the accept; IN_READY=0 thereafter; further IN_VALID causes no N_WE pulse.
4. Irregular source. WORDS=2; random IN_VALID gaps and IN_DATA changes while IN_READY=0 -> only handshaken bytes are written; exactly 8 strobes; N_WE never low outside STROBE; data stable from SETUP through HOLD.
5. Reset mid-operation. RST during the STROBE of byte 5 -> N_WE=1 next cycle, ADDR=0, PLANE=3. A subsequent full good image completes with N_BOOTED=0.
6. Full depth. Default parameters with 16384 bytes of pattern (index & 0xFF) plus the correct checksum -> last strobe at ADDR=0xFFF, PLANE=0; no address wrap; N_BOOTED=0; ERROR=0.
